// File: rtl/frog_pkg.sv
// Shared types for the frog move pulse generator: arbitration states,
// direction bit positions and a one-hot test for the debounced key vector.
package frog_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      CONFLICT = 2'd2
   } frog_state_e;

   // Bit positions inside the 4-bit key / pulse vectors (match KEY[] order)
   localparam int DIR_R = 0;
   localparam int DIR_D = 1;
   localparam int DIR_U = 2;
   localparam int DIR_L = 3;

   localparam int NUM_KEYS = 4;

   // True when exactly one key of the vector is pressed
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/frog_move_gen_key_debounce.sv
// One push-button channel: two-flop synchronizer on the raw active-low key,
// inversion to active-high, and a consecutive-sample debounce counter.
// The debounced level flips on the DEBOUNCE_CYCLES-th consecutive edge on
// which the synchronized level disagrees with it; any agreeing edge clears
// the count.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed;

   // Next-state: shift the synchronizer, count disagreeing edges, flip on the last one
   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      pressed = ~sync2_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (pressed != deb_q) begin
         if (cnt_q >= CNT_LAST) begin
            deb_d = ~deb_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers; reset leaves the key looking released
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = deb_q;

endmodule

// File: rtl/frog_move_gen.sv
// Frog move pulse generator: four debounced push-buttons feed an
// IDLE/HELD/CONFLICT arbiter that emits one registered single-cycle pulse
// per accepted press on L, R, D or U. Pressing two keys together, or
// changing keys while one is held, parks the arbiter in CONFLICT until all
// keys are released.
// Optional auto-repeat is built when the macro FROG_AUTOREPEAT_EN is defined.
// Handshake: there is none; L/R/D/U are fire-and-forget one-cycle strobes
// that every frog cell samples on the next rising edge.
module frog_move_gen
   import frog_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  KEY,
   input  logic        enable,
   output logic        L,
   output logic        R,
   output logic        D,
   output logic        U,
   output logic        conflict,
   output frog_state_e dbg_state,
   output logic [3:0]  dbg_keys
);

   // Elaboration-time sanity check on the timing parameters
   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("frog_move_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic [3:0] deb_vec;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .reset (reset),
         .key_n (KEY[i]),
         .level (deb_vec[i])
      );
   end

   frog_state_e state_q, state_d;
   logic [3:0]  dir_q, dir_d;
   logic [3:0]  pulse_q, pulse_d;
   logic        conflict_q, conflict_d;

`ifdef FROG_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   // armed: the entry pulse was enabled; first: the long initial delay is still pending
   logic          armed_q, armed_d;
   logic          first_q, first_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic [RW-1:0] rep_limit;
`endif

   // Arbitration next-state and pulse generation from the debounced vector
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pulse_d = '0;
`ifdef FROG_AUTOREPEAT_EN
      armed_d   = armed_q;
      first_d   = first_q;
      rep_cnt_d = rep_cnt_q;
      rep_limit = first_q ? DELAY_LAST : PERIOD_LAST;
`endif
      case (state_q)
         IDLE: begin
            if (deb_vec != 4'd0) begin
               if (is_onehot4(deb_vec)) begin
                  state_d = HELD;
                  dir_d   = deb_vec;
                  pulse_d = enable ? deb_vec : 4'd0;
`ifdef FROG_AUTOREPEAT_EN
                  armed_d   = enable;
                  first_d   = 1'b1;
                  rep_cnt_d = '0;
`endif
               end else begin
                  state_d = CONFLICT;
               end
            end
         end
         HELD: begin
            if (deb_vec == dir_q) begin
`ifdef FROG_AUTOREPEAT_EN
               if (armed_q) begin
                  if (rep_cnt_q >= rep_limit) begin
                     rep_cnt_d = '0;
                     first_d   = 1'b0;
                     pulse_d   = enable ? dir_q : 4'd0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + RW'(1);
                  end
               end
`endif
            end else begin
               state_d = (deb_vec == 4'd0) ? IDLE : CONFLICT;
`ifdef FROG_AUTOREPEAT_EN
               armed_d   = 1'b0;
               first_d   = 1'b0;
               rep_cnt_d = '0;
`endif
            end
         end
         CONFLICT: begin
            if (deb_vec == 4'd0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      conflict_d = (state_d == CONFLICT);
   end

   // Arbiter registers, including the registered pulse and conflict outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dir_q      <= '0;
         pulse_q    <= '0;
         conflict_q <= 1'b0;
`ifdef FROG_AUTOREPEAT_EN
         armed_q    <= 1'b0;
         first_q    <= 1'b0;
         rep_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pulse_q    <= pulse_d;
         conflict_q <= conflict_d;
`ifdef FROG_AUTOREPEAT_EN
         armed_q    <= armed_d;
         first_q    <= first_d;
         rep_cnt_q  <= rep_cnt_d;
`endif
      end
   end

   assign R         = pulse_q[DIR_R];
   assign D         = pulse_q[DIR_D];
   assign U         = pulse_q[DIR_U];
   assign L         = pulse_q[DIR_L];
   assign conflict  = conflict_q;
   assign dbg_state = state_q;
   assign dbg_keys  = deb_vec;

endmodule

// File: tb/tb_frog_move_gen.sv
// Bench for frog_move_gen with short timing parameters. A behavioural model
// tracks raw key history, run lengths of disagreeing samples, and a simple
// mode/direction arbiter; every clock step compares pulses, conflict, state
// and debounced keys. Directed scenarios add explicit timing checks.
module tb_frog_move_gen;
   import frog_pkg::*;

   localparam int DEB  = 4;
   localparam int RDLY = 8;
   localparam int RPER = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  key = 4'hF;
   logic        enable = 1'b1;
   logic        l_o, r_o, d_o, u_o, conflict_o;
   frog_state_e dbg_state;
   logic [3:0]  dbg_keys;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frog_move_gen #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RDLY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .KEY       (key),
      .enable    (enable),
      .L         (l_o),
      .R         (r_o),
      .D         (d_o),
      .U         (u_o),
      .conflict  (conflict_o),
      .dbg_state (dbg_state),
      .dbg_keys  (dbg_keys)
   );

   // ---------------- reference model ----------------
   logic [3:0] m_raw_q[$];   // raw KEY samples of the last two edges
   logic [3:0] m_deb;
   int         m_run[4];
   int         m_mode;       // 0 idle, 1 held, 2 conflict
   logic [3:0] m_dir;
   logic [3:0] m_pulse;
   logic       m_conf;
   logic       m_armed;
   int         m_next_fire;
   int         m_edge = 0;

   task automatic model_edge(input logic [3:0] k, input logic en, input logic rst);
      logic [3:0] vec, synced, nxt;
      if (rst) begin
         m_raw_q = '{4'hF, 4'hF};
         m_deb = 4'd0;
         foreach (m_run[i]) m_run[i] = 0;
         m_mode = 0;
         m_dir = 4'd0;
         m_pulse = 4'd0;
         m_conf = 1'b0;
         m_armed = 1'b0;
         m_next_fire = 0;
      end else begin
         vec = m_deb;
         nxt = 4'd0;
         case (m_mode)
            0: begin
               if ($countones(vec) == 1) begin
                  m_mode = 1;
                  m_dir = vec;
                  m_armed = en;
                  m_next_fire = m_edge + RDLY;
                  if (en) nxt = vec;
               end else if (vec != 4'd0) begin
                  m_mode = 2;
               end
            end
            1: begin
               if (vec == m_dir) begin
`ifdef FROG_AUTOREPEAT_EN
                  if (m_armed && m_edge == m_next_fire) begin
                     m_next_fire = m_edge + RPER;
                     if (en) nxt = m_dir;
                  end
`endif
               end else begin
                  m_mode = (vec == 4'd0) ? 0 : 2;
               end
            end
            default: if (vec == 4'd0) m_mode = 0;
         endcase
         m_pulse = nxt;
         m_conf = (m_mode == 2);
         synced = ~m_raw_q[0];
         for (int i = 0; i < 4; i++) begin
            if (synced[i] !== m_deb[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DEB) begin
               m_deb[i] = ~m_deb[i];
               m_run[i] = 0;
            end
         end
         m_raw_q.push_back(k);
         void'(m_raw_q.pop_front());
      end
      m_edge++;
   endtask

   // Drive one clock with the given inputs and compare against the model
   task automatic step(input logic [3:0] k, input logic en, input logic rst);
      logic [3:0]  obs;
      frog_state_e exp_st;
      key = k;
      enable = en;
      reset = rst;
      @(posedge clk);
      model_edge(k, en, rst);
      #1;
      obs = {l_o, u_o, d_o, r_o};
      exp_st = (m_mode == 0) ? IDLE : (m_mode == 1) ? HELD : CONFLICT;
      checks++;
      if (obs !== m_pulse) begin
         errors++;
         $display("FAIL pulses edge %0d: got LUDR=%b expected %b", m_edge - 1, obs, m_pulse);
      end
      checks++;
      if (conflict_o !== m_conf) begin
         errors++;
         $display("FAIL conflict edge %0d: got %b expected %b", m_edge - 1, conflict_o, m_conf);
      end
      checks++;
      if (dbg_state !== exp_st) begin
         errors++;
         $display("FAIL state edge %0d: got %0d expected %0d", m_edge - 1, dbg_state, exp_st);
      end
      checks++;
      if (dbg_keys !== m_deb) begin
         errors++;
         $display("FAIL debounced edge %0d: got %b expected %b", m_edge - 1, dbg_keys, m_deb);
      end
   endtask

   task automatic release_keys(input int n);
      for (int i = 0; i < n; i++) step(4'hF, 1'b1, 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b1);
      checks++;
      if ({l_o, u_o, d_o, r_o, conflict_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000", {l_o, u_o, d_o, r_o, conflict_o});
      end
      checks++;
      if (dbg_state !== IDLE || dbg_keys !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got state %0d keys %b expected 0 and 0000", dbg_state, dbg_keys);
      end
   endtask

   task automatic test_single_press();
      int first, cnt, exp_cnt;
      first = -1;
      cnt = 0;
`ifdef FROG_AUTOREPEAT_EN
      exp_cnt = 3;   // edges 6, 14, 18 fall inside the 20-cycle hold
`else
      exp_cnt = 1;
`endif
      for (int i = 0; i < 20; i++) begin
         step(4'b1110, 1'b1, 1'b0);
         if (r_o === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (first != DEB + 2) begin
         errors++;
         $display("FAIL single_press_latency: first R after edge %0d expected %0d", first, DEB + 2);
      end
      checks++;
      if (cnt != exp_cnt) begin
         errors++;
         $display("FAIL single_press_count: got %0d R pulses expected %0d", cnt, exp_cnt);
      end
      release_keys(10);
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      for (int i = 0; i < 2; i++) step(4'b1110, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(4'hF, 1'b1, 1'b0);
         if (r_o !== 1'b0 || dbg_keys[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL glitch: %0d cycles with pulse or debounced right set, expected 0", bad);
      end
   endtask

   task automatic test_conflict();
      int pulses, ups;
      pulses = 0;
      ups = 0;
      for (int i = 0; i < 10; i++) begin
         step(4'b0110, 1'b1, 1'b0);
         if ({l_o, u_o, d_o, r_o} !== 4'd0) pulses++;
      end
      checks++;
      if (conflict_o !== 1'b1 || pulses != 0) begin
         errors++;
         $display("FAIL conflict_pair: conflict %b pulses %0d expected 1 and 0", conflict_o, pulses);
      end
      release_keys(10);
      checks++;
      if (conflict_o !== 1'b0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL conflict_release: conflict %b state %0d expected 0 and IDLE", conflict_o, dbg_state);
      end
      for (int i = 0; i < 10; i++) begin
         step(4'b1011, 1'b1, 1'b0);
         if (u_o === 1'b1) ups++;
         if ({l_o, d_o, r_o} !== 3'd0) pulses++;
      end
      checks++;
      if (ups != 1 || pulses != 0) begin
         errors++;
         $display("FAIL conflict_then_up: U pulses %0d other %0d expected 1 and 0", ups, pulses);
      end
      release_keys(10);
   endtask

   task automatic test_add_key();
      int ls, other;
      ls = 0;
      other = 0;
      for (int i = 0; i < 8; i++) begin
         step(4'b0111, 1'b1, 1'b0);
         if (l_o === 1'b1) ls++;
         if ({u_o, d_o, r_o} !== 3'd0) other++;
      end
      for (int i = 0; i < 10; i++) begin
         step(4'b0101, 1'b1, 1'b0);
         if (l_o === 1'b1) ls++;
         if ({u_o, d_o, r_o} !== 3'd0) other++;
      end
      checks++;
      if (conflict_o !== 1'b1) begin
         errors++;
         $display("FAIL add_key_conflict: got %b expected 1", conflict_o);
      end
      for (int i = 0; i < 10; i++) begin
         step(4'hF, 1'b1, 1'b0);
         if ({l_o, u_o, d_o, r_o} !== 4'd0) other++;
      end
      checks++;
      if (ls != 1 || other != 0 || conflict_o !== 1'b0) begin
         errors++;
         $display("FAIL add_key_pulses: L %0d other %0d conflict %b expected 1 0 0", ls, other, conflict_o);
      end
   endtask

`ifdef FROG_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int pe[$];
      for (int i = 0; i < 40; i++) begin
         step(4'b1011, 1'b1, 1'b0);
         if (u_o === 1'b1) pe.push_back(i);
      end
      for (int k = 1; k <= 6; k++) begin
         checks++;
         if (pe.size() <= k) begin
            errors++;
            $display("FAIL autorepeat_missing: repeat %0d absent", k);
         end else if (pe[k] - pe[0] != RDLY + RPER * (k - 1)) begin
            errors++;
            $display("FAIL autorepeat_offset: repeat %0d at +%0d expected +%0d", k, pe[k] - pe[0], RDLY + RPER * (k - 1));
         end
      end
      release_keys(10);
   endtask
`endif

   task automatic test_reset_mid_hold();
      int first, ups, bad;
      first = -1;
      ups = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) step(4'b1011, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(4'b1011, 1'b1, 1'b1);
         if ({l_o, u_o, d_o, r_o, conflict_o} !== 5'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_hold_outputs: %0d nonzero cycles expected 0", bad);
      end
      // index 0 is the first edge with reset low
      for (int i = 0; i < 12; i++) begin
         step(4'b1011, 1'b1, 1'b0);
         if (u_o === 1'b1) begin
            ups++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (first != DEB + 2 || ups != 1) begin
         errors++;
         $display("FAIL reset_hold_repress: first U at %0d count %0d expected %0d and 1", first, ups, DEB + 2);
      end
      release_keys(10);
   endtask

   task automatic test_enable_low();
      int pulses, rs;
      pulses = 0;
      rs = 0;
      for (int i = 0; i < 12; i++) begin
         step(4'b1110, 1'b0, 1'b0);
         if ({l_o, u_o, d_o, r_o} !== 4'd0) pulses++;
      end
      for (int i = 0; i < 6; i++) begin
         step(4'b1110, 1'b1, 1'b0);
         if ({l_o, u_o, d_o, r_o} !== 4'd0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL enable_low: %0d pulses expected 0", pulses);
      end
      release_keys(8);
      for (int i = 0; i < 10; i++) begin
         step(4'b1110, 1'b1, 1'b0);
         if (r_o === 1'b1) rs++;
      end
      checks++;
      if (rs != 1) begin
         errors++;
         $display("FAIL enable_repress: %0d R pulses expected 1", rs);
      end
      release_keys(8);
   endtask

   task automatic test_random();
      logic [3:0] k;
      logic       en, rst;
      int         dur, sel;
      k = 4'hF;
      for (int n = 0; n < 70; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: k = 4'hF;
            1: k = ~(4'b0001 << $urandom_range(0, 3));
            2: k = 4'($urandom_range(0, 15));
            default: ;
         endcase
         dur = $urandom_range(1, 12);
         en  = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 31) == 0);
         for (int j = 0; j < dur; j++) step(k, en, rst && (j == 0));
      end
      release_keys(10);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_conflict();
      test_add_key();
`ifdef FROG_AUTOREPEAT_EN
      test_autorepeat();
`endif
      test_reset_mid_hold();
      test_enable_low();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/frog_move_gen.md
FROG_MOVE_GEN -- requirements
Module: frog_move_gen

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable synchronized samples required to accept a key level change (minimum 1).
- REQ-002: Parameter REPEAT_DELAY, default 25000000, hold cycles from the first pulse to the first auto-repeat pulse.
- REQ-003: Parameter REPEAT_PERIOD, default 10000000, cycles between later auto-repeat pulses.
- REQ-004: clk  input  1  system clock; all logic on posedge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: KEY  input  4  raw, asynchronous, active-low push-buttons: KEY[3]=left, KEY[2]=up, KEY[1]=down, KEY[0]=right.
- REQ-007: enable  input  1  high = move pulses permitted; low = all pulses suppressed.
- REQ-008: L, R, D, U  output  1 each  registered single-cycle move pulses consumed by every frog cell.
- REQ-009: conflict  output  1  registered; high while the state machine is in CONFLICT.

Function
- REQ-010: Each KEY bit shall pass through a 2-flop synchronizer, then be inverted to active-high before debouncing.
- REQ-011: Debounce per key: counter increments on each edge where the synchronized level differs from the debounced level and clears on any edge where they match; the debounced level toggles on the DEBOUNCE_CYCLES-th consecutive mismatching edge, and the counter clears.
- REQ-012: Latency: if edge k is the first edge to sample a new raw level, the debounced bit changes after edge k+1+DEBOUNCE_CYCLES, and any resulting pulse is high for the one cycle after edge k+2+DEBOUNCE_CYCLES.
- REQ-013: State machine states: IDLE, HELD, CONFLICT. The state machine acts only on the 4-bit debounced vector.
- REQ-014: In IDLE, with exactly one debounced bit set: move to HELD, latch that direction, and pulse its output for exactly one cycle if enable=1.
- REQ-015: In IDLE, with two or more bits set on the same edge: move to CONFLICT with no pulse.
- REQ-016: In IDLE, with zero bits set: stay in IDLE.
- REQ-017: In HELD, if the vector equals the latched direction: stay in HELD.
- REQ-018: In HELD, if the vector is all zero: move to IDLE.
- REQ-019: In HELD, any other vector (an added key, or a different key): move to CONFLICT with no pulse.
- REQ-020: In CONFLICT, outputs L, R, D and U stay low; the state returns to IDLE only on the edge where the vector is all zero.
- REQ-021: At most one of L, R, D, U shall be high in any cycle.
- REQ-022: No output pulse shall ever last more than one cycle.
- REQ-023: When enable=0, the state machine still tracks keys but L, R, D and U are forced low. A key already held when enable rises produces no pulse until it is released and pressed again.
- REQ-024: Counter widths shall be $clog2(parameter+1). Counters saturate and never wrap.

Reset
- REQ-025: reset=1 on an edge shall set: state to IDLE; synchronizer flops to 1 (released); debounced levels to 0; all counters to 0; L, R, D, U and conflict to 0.
- REQ-026: Reset asserted mid-hold or mid-debounce takes effect on that edge. After release, a key still held must complete a full debounce and then produces one pulse.

Configuration
- REQ-027: Macro FROG_AUTOREPEAT_EN defined: while in HELD with an enabled pulse emitted, a repeat counter shall emit a further pulse of the latched direction REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles.
- REQ-028: With FROG_AUTOREPEAT_EN defined, leaving HELD clears the repeat counter.
- REQ-029: Macro FROG_AUTOREPEAT_EN undefined: each press yields exactly one pulse, and the repeat counter and parameters are unused (no logic).

Structure
- REQ-030: Package frog_pkg shall hold the state enum (IDLE, HELD, CONFLICT) and the direction index constants DIR_R=0, DIR_D=1, DIR_U=2, DIR_L=3.
- REQ-031: Sub-module key_debounce (one synchronizer, counter and debounced output) shall be instantiated four times. Arbitration and pulse generation stay in frog_move_gen.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, enable=1 unless stated)
- REQ-032: KEY=4'b1110 first sampled at edge 0 and held 20 cycles -> R high only in the cycle after edge 6, with no further pulse and macro off.
- REQ-033: KEY[0] glitches low for 2 cycles, then high -> no pulse, and the debounced level stays 0.
- REQ-034: KEY=4'b0110 (left and right) pressed together -> conflict=1 with no pulse. Release both -> return to IDLE. Press KEY=4'b1011 (up) -> exactly one U pulse.
- REQ-035: Hold left, then add down -> one L pulse, then conflict=1. Release all -> conflict=0, no further pulses.
- REQ-036: With FROG_AUTOREPEAT_EN, hold up for 30 cycles after the first U pulse -> U pulses at offsets +8, +12, +16, +20, +24 and +28 cycles after the first.
- REQ-037: Reset asserted while up is held in HELD, then deasserted -> all outputs 0 during reset, then one U pulse DEBOUNCE_CYCLES+3 edges after release, since the key is still held. Separately, enable=0 during a press -> no pulse.
